// File: rtl/piso_reg_pkg.sv
// Shared helpers for the parallel-in serial-out shifter.
package piso_reg_pkg;

  // Bits needed to hold a count from 0 up to and including w.
  function automatic int unsigned cnt_width(int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Remaining-bit down-counter for piso_reg, with busy/last decode.
module piso_bit_counter
  import piso_reg_pkg::*;
#(
  parameter int unsigned Width = 8,
  parameter int unsigned CntW  = cnt_width(Width)
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic busy,
  output logic last
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CntW'(Width);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);
  assign last = (cnt_q == CntW'(1));

endmodule

// File: rtl/piso_reg.sv
// Parallel-in serial-out shift register; dout is the registered head bit.
module piso_reg
  import piso_reg_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          FILL      = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             dout,
  output logic             busy,
  output logic             last
);

  logic [WIDTH-1:0] sr_q, sr_d;

  // Shift every non-load cycle; din is only looked at under load so X cannot leak in.
  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = din;
    end else if (MSB_FIRST) begin
      sr_d = {sr_q[WIDTH-2:0], FILL};
    end else begin
      sr_d = {FILL, sr_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign dout = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

  piso_bit_counter #(
    .Width (WIDTH),
    .CntW  (cnt_width(WIDTH))
  ) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .busy  (busy),
    .last  (last)
  );

endmodule

// File: tb/tb_piso_reg.sv
// Scoreboard bench for piso_reg: driver queues expected {dout,busy,last}, monitor compares.
module tb_piso_reg;

  logic       clk = 1'b0;
  logic       reset, load;
  logic [7:0] din;
  logic       dout, busy, last;

  int checks   = 0;
  int failures = 0;

  logic [2:0] exp_q[$];
  string      name_q[$];

  always #5 clk = ~clk;

  piso_reg #(
    .WIDTH     (8),
    .MSB_FIRST (1'b1),
    .FILL      (1'b0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .din   (din),
    .dout  (dout),
    .busy  (busy),
    .last  (last)
  );

  // Drive one cycle of inputs, then queue what the outputs must read after that edge.
  task automatic step(input logic r, input logic l, input logic [7:0] d,
                      input logic ed, input logic eb, input logic el, input string nm);
    @(negedge clk);
    reset = r;
    load  = l;
    din   = l ? d : 8'($urandom);
    @(posedge clk);
    exp_q.push_back({ed, eb, el});
    name_q.push_back(nm);
  endtask

  task automatic shift_rest(input logic [7:0] w, input string nm);
    for (int k = 1; k < 8; k++) begin
      step(1'b0, 1'b0, 8'h00, w[7-k], 1'b1, (k == 7), nm);
    end
  endtask

  task automatic send_word(input logic [7:0] w, input string nm);
    step(1'b0, 1'b1, w, w[7], 1'b1, 1'b0, nm);
    shift_rest(w, nm);
  endtask

  task automatic idle(input int n, input string nm);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, nm);
    end
  endtask

  // Monitor: outputs are presented every cycle; sample 1 ns after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        logic [2:0] e;
        string      nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if ({dout, busy, last} !== e) begin
          failures++;
          $display("FAIL %s: got dout/busy/last=%b%b%b required %b%b%b at %0t",
                   nm, dout, busy, last, e[2], e[1], e[0], $time);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    load  = 1'b0;
    din   = 8'h00;

    // Reset beats load.
    step(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, "reset");
    step(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, "reset");

    send_word(8'b1011_0011, "word_b3");
    idle(4, "idle_after_b3");

    idle(10, "idle_gap");
    send_word(8'b1100_1100, "word_cc");
    idle(2, "idle_after_cc");

    // Mid-word reload after three bits of F0.
    step(1'b0, 1'b1, 8'hF0, 1'b1, 1'b1, 1'b0, "reload_f0");
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, "reload_f0");
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, "reload_f0");
    send_word(8'h0F, "reload_0f");
    idle(2, "idle_after_0f");

    // Held load keeps the head bit and a full count (busy, not last).
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0, "hold_load");
    end
    shift_rest(8'h80, "hold_release");
    idle(2, "idle_after_80");

    // Reset during the 4th bit of AA aborts the word.
    step(1'b0, 1'b1, 8'hAA, 1'b1, 1'b1, 1'b0, "abort_aa");
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "abort_aa");
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, "abort_aa");
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "abort_aa");
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "abort_reset");
    idle(1, "abort_idle");
    send_word(8'h5A, "after_abort");
    idle(3, "final_idle");

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
